// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the memory responder.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_mem_bank.sv
// Beat-wide backing store: byte-enable write port and a read-first synchronous read port.
module axi_mem_bank #(
    parameter int DATA_WD    = 256,
    parameter int WORDS_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [WORDS_LOG2-1:0] wr_idx,
    input  logic [DATA_WD-1:0]    wr_data,
    input  logic [DATA_WD/8-1:0]  wr_strb,
    input  logic                  rd_en,
    input  logic [WORDS_LOG2-1:0] rd_idx,
    output logic [DATA_WD-1:0]    rd_data
);

    logic [DATA_WD-1:0] mem_q [2**WORDS_LOG2];
    logic [DATA_WD-1:0] rd_data_q;

    // NOTE: the array and its read register carry no reset so the store maps onto RAM and survives a reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WD / 8; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a single-beat-wide store; independent read and write paths,
// one outstanding transaction each, with OKAY/SLVERR/DECERR classification.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int                 ADDR_WD    = 36,
    parameter int                 DATA_WD    = 256,
    parameter int                 ID_WD      = 14,
    parameter int                 WORDS_LOG2 = 12,
    parameter logic [ADDR_WD-1:0] BASE       = 36'h0_8000_0000
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ID_WD-1:0]     aw_id,
    input  logic [ADDR_WD-1:0]   aw_addr,
    input  logic [7:0]           aw_len,
    input  logic [2:0]           aw_size,
    input  logic [1:0]           aw_burst,

    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WD-1:0]   w_data,
    input  logic [DATA_WD/8-1:0] w_strb,
    input  logic                 w_last,

    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [ID_WD-1:0]     b_id,
    output logic [1:0]           b_resp,

    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ID_WD-1:0]     ar_id,
    input  logic [ADDR_WD-1:0]   ar_addr,
    input  logic [7:0]           ar_len,
    input  logic [2:0]           ar_size,
    input  logic [1:0]           ar_burst,

    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [ID_WD-1:0]     r_id,
    output logic [DATA_WD-1:0]   r_data,
    output logic [1:0]           r_resp,
    output logic                 r_last
);

    localparam int               BEAT_LOG2 = $clog2(DATA_WD / 8);
    localparam logic [ADDR_WD:0] WIN_LO    = {1'b0, BASE};
    localparam logic [ADDR_WD:0] WIN_HI    = WIN_LO + ((ADDR_WD + 1)'(1) << (WORDS_LOG2 + BEAT_LOG2));

    function automatic axi_resp_e classify(input logic [ADDR_WD-1:0] addr,
                                           input logic [1:0]         burst,
                                           input logic [2:0]         size);
        logic [ADDR_WD:0] a;
        a = {1'b0, addr};
        if (a < WIN_LO || a >= WIN_HI) return RESP_DECERR;
        if (burst != BURST_INCR || size != 3'(BEAT_LOG2)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    w_state_e              w_state_q, w_state_d;
    axi_resp_e             w_resp_q,  w_resp_d;
    logic [ID_WD-1:0]      w_id_q,    w_id_d;
    logic [WORDS_LOG2-1:0] w_idx_q,   w_idx_d;
    logic [7:0]            w_len_q,   w_len_d;
    logic [7:0]            w_cnt_q,   w_cnt_d;
    logic                  w_mismatch;
    logic                  mem_wr_en;

    r_state_e              r_state_q, r_state_d;
    axi_resp_e             r_resp_q,  r_resp_d;
    logic [ID_WD-1:0]      r_id_q,    r_id_d;
    logic [WORDS_LOG2-1:0] r_idx_q,   r_idx_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic                  mem_rd_en;
    logic [WORDS_LOG2-1:0] mem_rd_idx;
    logic [DATA_WD-1:0]    mem_rd_data;

    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    always_comb begin
        w_state_d  = w_state_q;
        w_resp_d   = w_resp_q;
        w_id_d     = w_id_q;
        w_idx_d    = w_idx_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        mem_wr_en  = 1'b0;
        w_mismatch = w_last != (w_cnt_q == w_len_q);
        unique case (w_state_q)
            W_IDLE: if (aw_valid) begin
                w_id_d    = aw_id;
                w_idx_d   = aw_addr[BEAT_LOG2 +: WORDS_LOG2];
                w_len_d   = aw_len;
                w_cnt_d   = 8'd0;
                w_resp_d  = classify(aw_addr, aw_burst, aw_size);
                w_state_d = W_DATA;
            end
            // A w_last/len disagreement only shows on the beat where it happens, and it always ends the burst.
            W_DATA: if (w_valid) begin
                mem_wr_en = (w_resp_q == RESP_OKAY) && !w_mismatch;
                w_idx_d   = w_idx_q + WORDS_LOG2'(1);
                w_cnt_d   = w_cnt_q + 8'd1;
                if (w_last || w_cnt_q == w_len_q) begin
                    w_state_d = W_RESP;
                    if (w_resp_q == RESP_OKAY && w_mismatch) w_resp_d = RESP_SLVERR;
                end
            end
            W_RESP: if (b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_resp_d   = r_resp_q;
        r_id_d     = r_id_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        mem_rd_en  = 1'b0;
        mem_rd_idx = r_idx_q;
        unique case (r_state_q)
            R_IDLE: if (ar_valid) begin
                r_id_d     = ar_id;
                r_len_d    = ar_len;
                r_cnt_d    = 8'd0;
                r_resp_d   = classify(ar_addr, ar_burst, ar_size);
                mem_rd_en  = 1'b1;
                mem_rd_idx = ar_addr[BEAT_LOG2 +: WORDS_LOG2];
                r_idx_d    = ar_addr[BEAT_LOG2 +: WORDS_LOG2] + WORDS_LOG2'(1);
                r_state_d  = R_DATA;
            end
            // Fetch the next beat on the handshake edge so the data lands with the next r_valid cycle.
            R_DATA: if (r_ready) begin
                if (r_cnt_q == r_len_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d   = r_cnt_q + 8'd1;
                    mem_rd_en = 1'b1;
                    r_idx_d   = r_idx_q + WORDS_LOG2'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_resp_q  <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_resp_q  <= w_resp_d;
            r_state_q <= r_state_d;
            r_resp_q  <= r_resp_d;
        end
        w_id_q  <= w_id_d;
        w_idx_q <= w_idx_d;
        w_len_q <= w_len_d;
        w_cnt_q <= w_cnt_d;
        r_id_q  <= r_id_d;
        r_idx_q <= r_idx_d;
        r_len_q <= r_len_d;
        r_cnt_q <= r_cnt_d;
    end

    axi_mem_bank #(
        .DATA_WD    (DATA_WD),
        .WORDS_LOG2 (WORDS_LOG2)
    ) u_bank (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_idx  (w_idx_q),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_en   (mem_rd_en),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_rd_data)
    );

    assign aw_ready = (w_state_q == W_IDLE);
    assign w_ready  = (w_state_q == W_DATA);
    assign b_valid  = (w_state_q == W_RESP);
    assign b_id     = w_id_q;
    assign b_resp   = w_resp_q;

    assign ar_ready = (r_state_q == R_IDLE);
    assign r_valid  = (r_state_q == R_DATA);
    assign r_last   = r_valid && (r_cnt_q == r_len_q);
    assign r_id     = r_id_q;
    assign r_resp   = r_resp_q;
    assign r_data   = (r_resp_q == RESP_OKAY) ? mem_rd_data : '0;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: write/read bursts, strobes, error codes, stalls, reset.
module tb_axi_mem_responder;
    import axi_pkg::*;

    localparam logic [35:0] BASE = 36'h0_8000_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic         aw_valid, aw_ready;
    logic [13:0]  aw_id;
    logic [35:0]  aw_addr;
    logic [7:0]   aw_len;
    logic [2:0]   aw_size;
    logic [1:0]   aw_burst;
    logic         w_valid, w_ready, w_last;
    logic [255:0] w_data;
    logic [31:0]  w_strb;
    logic         b_valid, b_ready;
    logic [13:0]  b_id;
    logic [1:0]   b_resp;
    logic         ar_valid, ar_ready;
    logic [13:0]  ar_id;
    logic [35:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [2:0]   ar_size;
    logic [1:0]   ar_burst;
    logic         r_valid, r_ready, r_last;
    logic [13:0]  r_id;
    logic [255:0] r_data;
    logic [1:0]   r_resp;

    int checks   = 0;
    int failures = 0;

    logic [255:0] wdat [16];
    logic [31:0]  wstb [16];
    logic [255:0] rd_data_a [16];
    logic [1:0]   rd_resp_a [16];
    logic         rd_last_a [16];
    logic [13:0]  rd_id_a   [16];
    int           rd_n;

    always #5 clock = ~clock;

    axi_mem_responder dut (
        .clock    (clock),    .reset    (reset),
        .aw_valid (aw_valid), .aw_ready (aw_ready), .aw_id   (aw_id),   .aw_addr (aw_addr),
        .aw_len   (aw_len),   .aw_size  (aw_size),  .aw_burst(aw_burst),
        .w_valid  (w_valid),  .w_ready  (w_ready),  .w_data  (w_data),  .w_strb  (w_strb),
        .w_last   (w_last),
        .b_valid  (b_valid),  .b_ready  (b_ready),  .b_id    (b_id),    .b_resp  (b_resp),
        .ar_valid (ar_valid), .ar_ready (ar_ready), .ar_id   (ar_id),   .ar_addr (ar_addr),
        .ar_len   (ar_len),   .ar_size  (ar_size),  .ar_burst(ar_burst),
        .r_valid  (r_valid),  .r_ready  (r_ready),  .r_id    (r_id),    .r_data  (r_data),
        .r_resp   (r_resp),   .r_last   (r_last)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_burst(input logic [35:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input logic [13:0] id, input int nbeats,
                               input int b_hold, output bit ok, output logic [1:0] resp,
                               output logic [13:0] bid, output int b_wait, output bit b_stable);
        int n;
        ok = 1'b1;
        b_stable = 1'b1;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_burst = burst; aw_size = size; aw_id = id;
        n = 0;
        while (!aw_ready && n < 20) begin tick(); n++; end
        if (!aw_ready) ok = 1'b0;
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1; w_data = wdat[i]; w_strb = wstb[i]; w_last = (i == nbeats - 1);
            n = 0;
            while (!w_ready && n < 20) begin tick(); n++; end
            if (!w_ready) ok = 1'b0;
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_wait = 0;
        while (!b_valid && b_wait < 20) begin tick(); b_wait++; end
        if (!b_valid) ok = 1'b0;
        resp = b_resp;
        bid  = b_id;
        for (int i = 0; i < b_hold; i++) begin
            tick();
            if (b_valid !== 1'b1 || b_resp !== resp || b_id !== bid) b_stable = 1'b0;
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic read_burst(input logic [35:0] addr, input logic [7:0] len, input logic [13:0] id,
                              input bit stall, output bit ok, output bit first_lat, output int stall_bad);
        int n;
        bit done, toggle, have_prev;
        logic [255:0] p_data;
        logic [1:0]   p_resp;
        logic         p_last;
        ok = 1'b1; rd_n = 0; stall_bad = 0; done = 1'b0; toggle = 1'b0; have_prev = 1'b0;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = BURST_INCR; ar_size = 3'd5; ar_id = id;
        n = 0;
        while (!ar_ready && n < 20) begin tick(); n++; end
        if (!ar_ready) ok = 1'b0;
        tick();
        ar_valid = 1'b0;
        first_lat = r_valid;
        n = 0;
        while (!done && n < 200) begin
            r_ready = stall ? toggle : 1'b1;
            toggle  = !toggle;
            if (r_valid && have_prev && (r_data !== p_data || r_resp !== p_resp || r_last !== p_last))
                stall_bad++;
            have_prev = r_valid && !r_ready;
            p_data = r_data; p_resp = r_resp; p_last = r_last;
            if (r_valid && r_ready && rd_n < 16) begin
                rd_data_a[rd_n] = r_data; rd_resp_a[rd_n] = r_resp;
                rd_last_a[rd_n] = r_last; rd_id_a[rd_n]   = r_id;
                rd_n++;
                if (r_last) done = 1'b1;
            end
            tick();
            n++;
        end
        r_ready = 1'b0;
        if (!done) ok = 1'b0;
    endtask

    task automatic wr1(input logic [35:0] addr, input logic [255:0] data);
        bit ok, bst; logic [1:0] resp; logic [13:0] bid; int bw;
        wdat[0] = data; wstb[0] = '1;
        write_burst(addr, 8'd0, BURST_INCR, 3'd5, 14'h0, 1, 0, ok, resp, bid, bw, bst);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (aw_ready !== 1'b1) begin failures++; $display("FAIL reset_aw_ready got=%b exp=1", aw_ready); end
        checks++; if (ar_ready !== 1'b1) begin failures++; $display("FAIL reset_ar_ready got=%b exp=1", ar_ready); end
        checks++; if (w_ready !== 1'b0) begin failures++; $display("FAIL reset_w_ready got=%b exp=0", w_ready); end
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
        checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid got=%b exp=0", r_valid); end
        checks++; if (r_last !== 1'b0) begin failures++; $display("FAIL reset_r_last got=%b exp=0", r_last); end
        checks++; if (b_resp !== 2'd0) begin failures++; $display("FAIL reset_b_resp got=%0d exp=0", b_resp); end
        checks++; if (r_resp !== 2'd0) begin failures++; $display("FAIL reset_r_resp got=%0d exp=0", r_resp); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok, bst, lat; logic [1:0] resp; logic [13:0] bid; int bw, sb;
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin wdat[i] = {248'd0, pat[i]}; wstb[i] = '1; end
        write_burst(BASE + 36'h40, 8'd3, BURST_INCR, 3'd5, 14'h1A5, 4, 2, ok, resp, bid, bw, bst);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_write_done got=%b exp=1", ok); end
        checks++; if (resp !== 2'd0) begin failures++; $display("FAIL basic_b_resp got=%0d exp=0", resp); end
        checks++; if (bid !== 14'h1A5) begin failures++; $display("FAIL basic_b_id got=%0h exp=1a5", bid); end
        checks++; if (bw !== 0) begin failures++; $display("FAIL basic_b_latency got=%0d exp=0", bw); end
        checks++; if (bst !== 1'b1) begin failures++; $display("FAIL basic_b_stable got=%b exp=1", bst); end
        read_burst(BASE + 36'h40, 8'd3, 14'h2B6, 1'b0, ok, lat, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_read_done got=%b exp=1", ok); end
        checks++; if (lat !== 1'b1) begin failures++; $display("FAIL basic_r_latency got=%b exp=1", lat); end
        checks++; if (rd_n !== 4) begin failures++; $display("FAIL basic_beats got=%0d exp=4", rd_n); end
        checks++; if (rd_id_a[0] !== 14'h2B6) begin failures++; $display("FAIL basic_r_id got=%0h exp=2b6", rd_id_a[0]); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data_a[i] !== {248'd0, pat[i]}) begin failures++; $display("FAIL basic_r_data[%0d] got=%0h exp=%0h", i, rd_data_a[i], pat[i]); end
            checks++; if (rd_last_a[i] !== (i == 3)) begin failures++; $display("FAIL basic_r_last[%0d] got=%b exp=%b", i, rd_last_a[i], i == 3); end
            checks++; if (rd_resp_a[i] !== 2'd0) begin failures++; $display("FAIL basic_r_resp[%0d] got=%0d exp=0", i, rd_resp_a[i]); end
        end
        checks++; if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin failures++; $display("FAIL basic_r_idle got=%b%b exp=01", r_valid, ar_ready); end
    endtask

    task automatic test_strobe();
        bit ok, bst, lat; logic [1:0] resp; logic [13:0] bid; int bw, sb;
        wr1(BASE + 36'h200, '0);
        wdat[0] = '1; wstb[0] = 32'h0000_000F;
        write_burst(BASE + 36'h200, 8'd0, BURST_INCR, 3'd5, 14'h3, 1, 0, ok, resp, bid, bw, bst);
        wstb[0] = '1;
        checks++; if (resp !== 2'd0) begin failures++; $display("FAIL strobe_b_resp got=%0d exp=0", resp); end
        read_burst(BASE + 36'h200, 8'd0, 14'h4, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[0] !== 256'hFFFF_FFFF) begin failures++; $display("FAIL strobe_r_data got=%0h exp=ffffffff", rd_data_a[0]); end
    endtask

    task automatic test_decerr();
        bit ok, bst, lat; logic [1:0] resp; logic [13:0] bid; int bw, sb;
        wdat[0] = 256'hAAAA_0001; wdat[1] = 256'hBBBB_0002; wstb[0] = '1; wstb[1] = '1;
        write_burst(BASE + 36'h1FFE0, 8'd1, BURST_INCR, 3'd5, 14'h5, 2, 0, ok, resp, bid, bw, bst);
        checks++; if (resp !== 2'd0) begin failures++; $display("FAIL top_beat_b_resp got=%0d exp=0", resp); end
        read_burst(BASE + 36'h1FFE0, 8'd1, 14'h6, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[1] !== 256'hBBBB_0002) begin failures++; $display("FAIL wrap_r_data got=%0h exp=bbbb0002", rd_data_a[1]); end
        read_burst(BASE - 36'h20, 8'd1, 14'h7, 1'b0, ok, lat, sb);
        checks++; if (rd_n !== 2) begin failures++; $display("FAIL decerr_read_beats got=%0d exp=2", rd_n); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (rd_data_a[i] !== '0) begin failures++; $display("FAIL decerr_r_data[%0d] got=%0h exp=0", i, rd_data_a[i]); end
            checks++; if (rd_resp_a[i] !== 2'd3) begin failures++; $display("FAIL decerr_r_resp[%0d] got=%0d exp=3", i, rd_resp_a[i]); end
        end
        checks++; if (rd_last_a[1] !== 1'b1) begin failures++; $display("FAIL decerr_r_last got=%b exp=1", rd_last_a[1]); end
        wdat[0] = 256'hDEAD_0000; wdat[1] = 256'hDEAD_0001;
        write_burst(BASE - 36'h20, 8'd1, BURST_INCR, 3'd5, 14'h8, 2, 0, ok, resp, bid, bw, bst);
        checks++; if (resp !== 2'd3) begin failures++; $display("FAIL decerr_below_b_resp got=%0d exp=3", resp); end
        write_burst(BASE + 36'h20000, 8'd0, BURST_INCR, 3'd5, 14'h9, 1, 0, ok, resp, bid, bw, bst);
        checks++; if (resp !== 2'd3) begin failures++; $display("FAIL decerr_above_b_resp got=%0d exp=3", resp); end
        read_burst(BASE + 36'h20000, 8'd0, 14'hA, 1'b0, ok, lat, sb);
        checks++; if (rd_resp_a[0] !== 2'd3) begin failures++; $display("FAIL decerr_above_r_resp got=%0d exp=3", rd_resp_a[0]); end
        read_burst(BASE + 36'h1FFE0, 8'd1, 14'hB, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[0] !== 256'hAAAA_0001) begin failures++; $display("FAIL decerr_store0 got=%0h exp=aaaa0001", rd_data_a[0]); end
        checks++; if (rd_data_a[1] !== 256'hBBBB_0002) begin failures++; $display("FAIL decerr_store1 got=%0h exp=bbbb0002", rd_data_a[1]); end
    endtask

    task automatic test_stall();
        bit ok, bst, lat; logic [1:0] resp; logic [13:0] bid; int bw, sb;
        for (int i = 0; i < 8; i++) begin wdat[i] = {224'd0, 32'hC0DE_0000 + 32'(i)}; wstb[i] = '1; end
        write_burst(BASE + 36'h400, 8'd7, BURST_INCR, 3'd5, 14'hC, 8, 0, ok, resp, bid, bw, bst);
        read_burst(BASE + 36'h400, 8'd7, 14'hD, 1'b1, ok, lat, sb);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_read_done got=%b exp=1", ok); end
        checks++; if (rd_n !== 8) begin failures++; $display("FAIL stall_beats got=%0d exp=8", rd_n); end
        checks++; if (sb !== 0) begin failures++; $display("FAIL stall_hold_changes got=%0d exp=0", sb); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data_a[i] !== {224'd0, 32'hC0DE_0000 + 32'(i)}) begin failures++; $display("FAIL stall_r_data[%0d] got=%0h exp=%0h", i, rd_data_a[i], 32'hC0DE_0000 + 32'(i)); end
            checks++; if (rd_last_a[i] !== (i == 7)) begin failures++; $display("FAIL stall_r_last[%0d] got=%b exp=%b", i, rd_last_a[i], i == 7); end
        end
    endtask

    task automatic test_slverr();
        bit ok, bst, lat; logic [1:0] resp; logic [13:0] bid; int bw, sb;
        wr1(BASE + 36'h600, 256'h5A5A);
        for (int i = 0; i < 4; i++) begin wdat[i] = 256'hEE; wstb[i] = '1; end
        write_burst(BASE + 36'h600, 8'd3, BURST_WRAP, 3'd5, 14'hE, 4, 0, ok, resp, bid, bw, bst);
        checks++; if (resp !== 2'd2) begin failures++; $display("FAIL wrap_b_resp got=%0d exp=2", resp); end
        write_burst(BASE + 36'h600, 8'd0, BURST_INCR, 3'd4, 14'hF, 1, 0, ok, resp, bid, bw, bst);
        checks++; if (resp !== 2'd2) begin failures++; $display("FAIL size_b_resp got=%0d exp=2", resp); end
        read_burst(BASE + 36'h600, 8'd0, 14'h10, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[0] !== 256'h5A5A) begin failures++; $display("FAIL slverr_store got=%0h exp=5a5a", rd_data_a[0]); end
        write_burst(BASE + 36'h680, 8'd3, BURST_INCR, 3'd5, 14'h11, 3, 0, ok, resp, bid, bw, bst);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL early_last_done got=%b exp=1", ok); end
        checks++; if (resp !== 2'd2) begin failures++; $display("FAIL early_last_b_resp got=%0d exp=2", resp); end
        checks++; if (aw_ready !== 1'b1) begin failures++; $display("FAIL early_last_idle got=%b exp=1", aw_ready); end
    endtask

    task automatic test_same_beat();
        bit ok, lat; int sb;
        wr1(BASE + 36'h800, 256'h01D);
        aw_valid = 1'b1; aw_addr = BASE + 36'h800; aw_len = 8'd0; aw_burst = BURST_INCR; aw_size = 3'd5; aw_id = 14'h12;
        tick();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 256'h0E0; w_strb = '1; w_last = 1'b1;
        ar_valid = 1'b1; ar_addr = BASE + 36'h800; ar_len = 8'd0; ar_burst = BURST_INCR; ar_size = 3'd5; ar_id = 14'h13;
        tick();
        w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
        checks++; if (r_valid !== 1'b1) begin failures++; $display("FAIL same_beat_r_valid got=%b exp=1", r_valid); end
        checks++; if (r_data !== 256'h01D) begin failures++; $display("FAIL same_beat_old_data got=%0h exp=1d", r_data); end
        checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL same_beat_b_valid got=%b exp=1", b_valid); end
        r_ready = 1'b1; b_ready = 1'b1;
        tick();
        r_ready = 1'b0; b_ready = 1'b0;
        read_burst(BASE + 36'h800, 8'd0, 14'h14, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[0] !== 256'h0E0) begin failures++; $display("FAIL same_beat_new_data got=%0h exp=e0", rd_data_a[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok, lat; int sb;
        ar_valid = 1'b1; ar_addr = BASE + 36'h40; ar_len = 8'd3; ar_burst = BURST_INCR; ar_size = 3'd5; ar_id = 14'h15;
        tick();
        ar_valid = 1'b0;
        r_ready = 1'b1;
        tick(); tick();
        checks++; if (r_data !== 256'h33) begin failures++; $display("FAIL mid_beat2_data got=%0h exp=33", r_data); end
        reset = 1'b1;
        tick();
        checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_r_valid got=%b exp=0", r_valid); end
        checks++; if (ar_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ar_ready got=%b exp=1", ar_ready); end
        checks++; if (r_last !== 1'b0) begin failures++; $display("FAIL mid_reset_r_last got=%b exp=0", r_last); end
        reset = 1'b0; r_ready = 1'b0;
        aw_valid = 1'b1; aw_addr = BASE + 36'h900; aw_len = 8'd3; aw_burst = BURST_INCR; aw_size = 3'd5; aw_id = 14'h16;
        tick();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 256'h77; w_strb = '1; w_last = 1'b0;
        tick();
        w_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        checks++; if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin failures++; $display("FAIL mid_write_abandon got=%b%b exp=01", b_valid, aw_ready); end
        read_burst(BASE + 36'h40, 8'd3, 14'h17, 1'b0, ok, lat, sb);
        checks++; if (rd_data_a[0] !== 256'h11 || rd_data_a[3] !== 256'h44) begin failures++; $display("FAIL mid_store_kept got=%0h,%0h exp=11,44", rd_data_a[0], rd_data_a[3]); end
    endtask

    initial begin
        reset = 1'b1;
        aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        r_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin wdat[i] = '0; wstb[i] = '1; end
        test_reset();
        test_basic();
        test_strobe();
        test_decerr();
        test_stall();
        test_slverr();
        test_same_beat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WD, default 36, AXI address width.
REQ-002 SHALL have parameter DATA_WD, default 256, AXI data width; beat size is 32 bytes.
REQ-003 SHALL have parameter ID_WD, default 14, AXI ID width.
REQ-004 SHALL have parameter WORDS_LOG2, default 12, number of backing-store beats (2^12).
REQ-005 SHALL have parameter BASE, default 36'h0_8000_0000, base address of the window.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports aw_valid/aw_ready, in/out, 1/1, write-address handshake.
REQ-009 SHALL have ports aw_id/aw_addr/aw_len/aw_size/aw_burst, in, ID_WD/ADDR_WD/8/3/2, write-address fields.
REQ-010 SHALL have ports w_valid/w_ready, in/out, 1/1, write-data handshake.
REQ-011 SHALL have ports w_data/w_strb/w_last, in, DATA_WD/DATA_WD/8/1, write beat.
REQ-012 SHALL have ports b_valid/b_ready, out/in, 1/1, write-response handshake.
REQ-013 SHALL have ports b_id/b_resp, out, ID_WD/2, write response.
REQ-014 SHALL have ports ar_valid/ar_ready, in/out, 1/1, read-address handshake.
REQ-015 SHALL have ports ar_id/ar_addr/ar_len/ar_size/ar_burst, in, ID_WD/ADDR_WD/8/3/2, read-address fields.
REQ-016 SHALL have ports r_valid/r_ready, out/in, 1/1, read-data handshake.
REQ-017 SHALL have ports r_id/r_data/r_resp/r_last, out, ID_WD/DATA_WD/2/1, read beat.

Function
REQ-018 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; aw_ready = (state==W_IDLE), w_ready = (state==W_DATA), b_valid = (state==W_RESP).
REQ-019 AW handshake SHALL latch id, beat index = aw_addr[WORDS_LOG2+4:5], len, and error class; W_IDLE->W_DATA.
REQ-020 Each W handshake SHALL write bytes enabled by w_strb into the indexed beat; index increments modulo 2^WORDS_LOG2 (wrap within store).
REQ-021 W_DATA->W_RESP SHALL occur on the beat where w_last=1 or beat count reaches len+1, whichever comes first; b_valid rises the following cycle.
REQ-022 b_resp SHALL be OKAY(0); SLVERR(2) if aw_burst!=INCR, aw_size!=5, or w_last disagrees with len; DECERR(3) if address outside [BASE, BASE+2^(WORDS_LOG2+5)).
REQ-023 SLVERR/DECERR writes SHALL NOT modify the store but SHALL still consume all beats.
REQ-024 W_RESP->W_IDLE SHALL occur on b_ready; b_id/b_resp stable while b_valid && !b_ready.
REQ-025 Read FSM SHALL have states R_IDLE, R_DATA; ar_ready = (state==R_IDLE); AR handshake latches fields, R_IDLE->R_DATA.
REQ-026 First r_valid SHALL assert the cycle after AR handshake; one beat per cycle while r_ready=1 (no bubbles).
REQ-027 r_last SHALL assert on beat len; R_DATA->R_IDLE on its handshake; new AR accepted no earlier than the following cycle.
REQ-028 r_data/r_id/r_resp/r_last SHALL hold stable while r_valid && !r_ready.
REQ-029 Errored reads SHALL return r_data=0 with the REQ-022 code on every beat, full len+1 beats.
REQ-030 Same-cycle read and write to one beat SHALL return pre-write data.
REQ-031 Read and write paths SHALL be independent; one outstanding transaction per path.

Reset
REQ-032 Reset SHALL force both FSMs to idle; b_valid=0, r_valid=0, r_last=0, aw_ready=1, ar_ready=1, w_ready=0, b_resp=0, r_resp=0.
REQ-033 Reset mid-burst SHALL abandon the burst without response; store contents SHALL be retained.

Structure
REQ-034 Response codes, burst encodings and FSM state enums SHALL reside in shared package axi_pkg.
REQ-035 Backing store SHALL be one sub-module axi_mem_bank (byte-enable write, registered-index read).

Verification
REQ-036 AW addr BASE+0x40 len 3, four beats 0x11..0x44 full strb; then AR same -> b_resp 0, reads return 0x11..0x44, r_last on 4th.
REQ-037 Write strb 0x0000_000F data all-FF over zeroed beat -> read shows only bytes 0-3 = FF.
REQ-038 AR addr BASE-0x20 len 1 -> two beats r_data 0, r_resp 3; AW same -> b_resp 3, store unchanged.
REQ-039 Read len 7 with r_ready toggled every other cycle -> r_data stable under stall, 8 beats, no loss.
REQ-040 aw_burst WRAP, or w_last on beat 2 of len 3 -> b_resp 2.
REQ-041 Reset asserted during beat 2 of 4-beat read -> r_valid 0 next cycle, ar_ready 1, prior written data intact.
